// File: rtl/npu_mem_pkg.sv
// Shared constants and scheduler state type for the activation/weight RAM port logic.
package npu_mem_pkg;

  localparam int unsigned NPU_MEM_DEPTH = 20480;
  localparam int unsigned NPU_ADDR_W    = 16;
  localparam int unsigned NPU_DATA_W    = 16;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DONE
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = IDX_W'((32'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdp_burst_sched.sv
// Burst scheduler sharing one TDP RAM port between NUM_REQ requesters.
// Optional bounds rejection of bursts is enabled by defining TDP_BOUNDS_CHK_EN.
module tdp_burst_sched
  import npu_mem_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned ADDR_W    = NPU_ADDR_W,
  parameter int unsigned DATA_W    = NPU_DATA_W,
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned MEM_DEPTH = NPU_MEM_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  input  logic [NUM_REQ-1:0]        wd_valid,
  output logic [NUM_REQ-1:0]        wd_ready,
  input  logic [NUM_REQ*DATA_W-1:0] wd_data,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic [NUM_REQ-1:0]        done,
  output logic [NUM_REQ-1:0]        err,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_din,
  input  logic [DATA_W-1:0]         mem_dout
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_t        state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d, gidx_q, gidx_d, gidx_c;
  logic [NUM_REQ-1:0]  gnt, gnt_q, gnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, addr_nxt, acc_addr;
  logic [LEN_W-1:0]    len_q, len_d, cnt_q, cnt_d, acc_len;
  logic                we_q, we_d, fire, bad;
  logic [NUM_REQ-1:0]  rd_valid_q;
  logic [DATA_W-1:0]   rd_data_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  always_comb begin
    gidx_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gidx_c = IDX_W'(i);
    end
  end

  assign acc_addr = req_addr[gidx_c*ADDR_W +: ADDR_W];
  assign acc_len  = req_len[gidx_c*LEN_W +: LEN_W];

`ifdef TDP_BOUNDS_CHK_EN
  logic [ADDR_W:0] acc_end;
  logic            err_q;

  assign acc_end = {1'b0, acc_addr} + (ADDR_W+1)'(acc_len);
  assign bad     = ({1'b0, acc_addr} >= (ADDR_W+1)'(MEM_DEPTH)) ||
                   (acc_end >= (ADDR_W+1)'(MEM_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state_q == IDLE) begin
      err_q <= bad;
    end
  end

  assign err = (state_q == DONE && err_q) ? gnt_q : '0;
`else
  assign bad = 1'b0;
  assign err = '0;
`endif

  // Write beats fire only with data present; read beats fire every BURST cycle.
  assign fire     = (state_q == BURST) && (!we_q || wd_valid[gidx_q]);
  assign addr_nxt = (addr_q == ADDR_W'(MEM_DEPTH - 1)) ? '0 : addr_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          gidx_d  = gidx_c;
          gnt_d   = gnt;
          addr_d  = acc_addr;
          len_d   = acc_len;
          we_d    = req_we[gidx_c];
          cnt_d   = '0;
          state_d = bad ? DONE : BURST;
        end
      end
      BURST: begin
        if (fire) begin
          addr_d = addr_nxt;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == len_q) state_d = DONE;
        end
      end
      DONE: begin
        ptr_d   = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    wd_ready  = '0;
    done      = '0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    if (state_q == IDLE) req_ready = gnt;
    if (state_q == BURST) begin
      mem_addr = addr_q;
      if (we_q) begin
        wd_ready = gnt_q & wd_valid;
        mem_we   = fire;
        if (fire) mem_din = wd_data[gidx_q*DATA_W +: DATA_W];
      end
    end
    if (state_q == DONE) done = gnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gidx_q     <= '0;
      gnt_q      <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gidx_q     <= gidx_d;
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      rd_valid_q <= (fire && !we_q) ? gnt_q : '0;
      if (fire && !we_q) rd_data_q <= mem_dout;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_tdp_burst_sched.sv
// Self-checking bench for tdp_burst_sched with a RAM model and read/write scoreboards.
module tb_tdp_burst_sched;

  localparam int DEPTH = 20480;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_we;
  logic [31:0] req_addr;
  logic [15:0] req_len;
  logic [1:0]  wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic [1:0]  rd_valid, done, err;
  logic [15:0] rd_data;
  logic        mem_we;
  logic [15:0] mem_addr, mem_din, mem_dout;

  logic [15:0] mem [0:DEPTH-1];

  typedef struct { int req; logic [15:0] data; int cyc; } rd_item_t;
  typedef struct { logic [15:0] addr; logic [15:0] data; } wr_item_t;

  rd_item_t rd_q[$];
  wr_item_t wr_q[$];
  logic [1:0] gnt_log[$];

  int n_checks = 0, n_errors = 0, cyc = 0;
  int done_cnt[2], done_cyc[2], err_cnt[2], err_cyc[2];

  tdp_burst_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .wd_valid  (wd_valid),
    .wd_ready  (wd_ready),
    .wd_data   (wd_data),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .done      (done),
    .err       (err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_dout = (int'(mem_addr) < DEPTH) ? mem[mem_addr] : 16'h0;
  always @(posedge clk) if (mem_we && int'(mem_addr) < DEPTH) mem[mem_addr] <= mem_din;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      rd_item_t ri;
      wr_item_t wi;
      if (req_ready != 2'b00) gnt_log.push_back(req_ready);
      if (rd_valid != 2'b00) begin
        if (rd_q.size() == 0) check("rd_extra", 32'(rd_valid), 0);
        else begin
          ri = rd_q.pop_front();
          check("rd_req", 32'(rd_valid), 32'(1 << ri.req));
          check("rd_data", 32'(rd_data), 32'(ri.data));
          if (ri.cyc >= 0) check("rd_cyc", cyc, ri.cyc);
        end
      end
      if (mem_we) begin
        if (wr_q.size() == 0) check("wr_extra", 32'(mem_addr), 32'hffff_ffff);
        else begin
          wi = wr_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(wi.addr));
          check("wr_data", 32'(mem_din), 32'(wi.data));
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (done[r]) begin done_cnt[r]++; done_cyc[r] = cyc; end
        if (err[r]) begin err_cnt[r]++; err_cyc[r] = cyc; end
      end
`ifndef TDP_BOUNDS_CHK_EN
      if (err != 2'b00) check("err_zero", 32'(err), 0);
`endif
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input int r, input logic we, input logic [15:0] a, input logic [7:0] l,
                       output int t0);
    bit seen;
    seen = 1'b0;
    t0   = 0;
    req_we[r]           = we;
    req_addr[r*16 +: 16] = a;
    req_len[r*8 +: 8]    = l;
    req_valid[r]        = 1'b1;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (req_ready[r]) begin
        seen = 1'b1;
        t0   = cyc;
      end
    end
    check("accept", 32'(seen), 1);
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, d0, d1, e0;
    bit seen;
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0;
    mem[100] = 16'hA1A1; mem[101] = 16'hB2B2; mem[102] = 16'hC3C3; mem[103] = 16'hD4D4;
    mem[200] = 16'h2222; mem[300] = 16'h3333;
    req_valid = '0; req_we = '0; req_addr = '0; req_len = '0;
    wd_valid = '0; wd_data = '0; rst_n = 1'b0;
    for (int r = 0; r < 2; r++) begin
      done_cnt[r] = 0; done_cyc[r] = -1; err_cnt[r] = 0; err_cyc[r] = -1;
    end

    #12;
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_done", 32'(done), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_wd_ready", 32'(wd_ready), 0);
    check("rst_err", 32'(err), 0);
    #10 rst_n = 1'b1;
    tick(2);

    // Read burst, req0, 4 words
    issue(0, 1'b0, 16'd100, 8'd3, t0);
    rd_q.push_back('{0, 16'hA1A1, t0 + 2});
    rd_q.push_back('{0, 16'hB2B2, t0 + 3});
    rd_q.push_back('{0, 16'hC3C3, t0 + 4});
    rd_q.push_back('{0, 16'hD4D4, t0 + 5});
    tick(7);
    check("rd_done_cnt", done_cnt[0], 1);
    check("rd_done_cyc", done_cyc[0], t0 + 5);
    check("rd_left", rd_q.size(), 0);

    // Gapped write burst across the wrap point, req1
    issue(1, 1'b1, 16'd20478, 8'd3, t0);
    for (int k = 0; k < 4; k++) begin
      logic [15:0] a;
      a = 16'((20478 + k) % DEPTH);
      wd_valid[1] = 1'b1;
      wd_data[16 +: 16] = 16'hB000 + 16'(k);
      wr_q.push_back('{a, 16'hB000 + 16'(k)});
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        seen = wd_ready[1];
      end
      check("wd_ready", 32'(seen), 1);
      tick(1);
      wd_valid[1] = 1'b0;
      tick(1);
    end
    tick(3);
    check("wr_left", wr_q.size(), 0);
    check("wr_done_cnt", done_cnt[1], 1);
    check("ram_20478", 32'(mem[20478]), 32'hB000);
    check("ram_20479", 32'(mem[20479]), 32'hB001);
    check("ram_0", 32'(mem[0]), 32'hB002);
    check("ram_1", 32'(mem[1]), 32'hB003);

    // Both requesters always valid: grants must alternate starting at req0
    gnt_log.delete();
    d0 = done_cnt[0]; d1 = done_cnt[1];
    for (int i = 0; i < 8; i++) rd_q.push_back('{i % 2, (i % 2) ? 16'h3333 : 16'h2222, -1});
    req_we = 2'b00;
    req_addr = {16'd300, 16'd200};
    req_len = '0;
    req_valid = 2'b11;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = (gnt_log.size() >= 8);
    end
    check("alt_8_grants", 32'(seen), 1);
    tick(1);
    req_valid = 2'b00;
    tick(6);
    for (int i = 0; i < 8 && i < gnt_log.size(); i++) check("alt_gnt", 32'(gnt_log[i]), 32'(1 << (i % 2)));
    check("alt_rd_left", rd_q.size(), 0);
    check("alt_done0", done_cnt[0] - d0, 4);
    check("alt_done1", done_cnt[1] - d1, 4);

    // Reset during beat 2 of an 8-word write
    d0 = done_cnt[0];
    issue(0, 1'b1, 16'd500, 8'd7, t0);
    wd_valid[0] = 1'b1;
    wd_data[0 +: 16] = 16'h7000;
    wr_q.push_back('{16'd500, 16'h7000});
    tick(1);
    wd_data[0 +: 16] = 16'h7001;
    wr_q.push_back('{16'd501, 16'h7001});
    tick(1);
    wd_data[0 +: 16] = 16'h7002;
    #2 rst_n = 1'b0;
    #1;
    check("arst_mem_we", 32'(mem_we), 0);
    check("arst_mem_addr", 32'(mem_addr), 0);
    check("arst_wd_ready", 32'(wd_ready), 0);
    check("arst_done", 32'(done), 0);
    #20;
    wd_valid[0] = 1'b0;
    rst_n = 1'b1;
    tick(2);
    check("arst_ram_500", 32'(mem[500]), 32'h7000);
    check("arst_ram_501", 32'(mem[501]), 32'h7001);
    check("arst_ram_502", 32'(mem[502]), 32'h0);
    check("arst_no_done", done_cnt[0] - d0, 0);
    check("arst_wr_left", wr_q.size(), 0);
    issue(0, 1'b0, 16'd100, 8'd0, t0);
    rd_q.push_back('{0, 16'hA1A1, t0 + 2});
    tick(4);
    check("post_rst_done", done_cnt[0] - d0, 1);
    check("post_rst_rd_left", rd_q.size(), 0);

    // Burst running past the end of memory
    d0 = done_cnt[0]; e0 = err_cnt[0];
    issue(0, 1'b1, 16'd20470, 8'd15, t0);
`ifdef TDP_BOUNDS_CHK_EN
    wd_valid[0] = 1'b1;
    wd_data[0 +: 16] = 16'h5555;
    tick(5);
    wd_valid[0] = 1'b0;
    check("bnd_done_cyc", done_cyc[0], t0 + 1);
    check("bnd_err_cyc", err_cyc[0], t0 + 1);
    check("bnd_err_cnt", err_cnt[0] - e0, 1);
    check("bnd_ram_20470", 32'(mem[20470]), 32'h0);
`else
    wd_valid[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wd_data[0 +: 16] = 16'h5000 + 16'(i);
      wr_q.push_back('{16'((20470 + i) % DEPTH), 16'h5000 + 16'(i)});
      tick(1);
    end
    wd_valid[0] = 1'b0;
    tick(3);
    check("wrap_ram_20479", 32'(mem[20479]), 32'h5009);
    check("wrap_ram_5", 32'(mem[5]), 32'h500F);
    check("wrap_err_cnt", err_cnt[0] - e0, 0);
`endif
    check("bnd_done_cnt", done_cnt[0] - d0, 1);
    check("bnd_wr_left", wr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
